// File: rtl/jt51_pkg.sv
// Shared JT51 slot/operator definitions.
// Slot index = op*8 + ch, with the operator order M1, M2, C1, C2.
// The key-on register mask uses a different bit order:
// [0]=M1, [1]=C1, [2]=M2, [3]=C2.
// mask_to_slots() converts a register mask into slot bits. The register
// decoder can reuse it as well.
package jt51_pkg;

  localparam int NSLOTS = 32;

  localparam logic [1:0] OP_M1 = 2'd0;
  localparam logic [1:0] OP_M2 = 2'd1;
  localparam logic [1:0] OP_C1 = 2'd2;
  localparam logic [1:0] OP_C2 = 2'd3;

  // Write-holding state of the key-on sequencer
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } kon_state_t;

  // Places the four register mask bits of channel ch onto their slot positions.
  function automatic logic [NSLOTS-1:0] mask_to_slots(input logic [2:0] ch,
                                                      input logic [3:0] mask);
    logic [NSLOTS-1:0] s;
    s = '0;
    s[{OP_M1, ch}] = mask[0];
    s[{OP_C1, ch}] = mask[1];
    s[{OP_M2, ch}] = mask[2];
    s[{OP_C2, ch}] = mask[3];
    return s;
  endfunction

  // Returns all four slot positions that belong to channel ch.
  function automatic logic [NSLOTS-1:0] chan_slots(input logic [2:0] ch);
    return mask_to_slots(ch, 4'hf);
  endfunction

endpackage

// File: rtl/jt51_kon_seq_if.sv
// Key-on register write channel.
// Handshake: the master holds wr_valid, wr_ch and wr_mask stable until a
// clk edge where wr_valid && wr_ready is true. On that edge the write is
// accepted. The handshake is evaluated on every clk edge and is not gated
// by cen.
//   wr_valid : write request (master -> slave)
//   wr_ready : slave can accept a write (slave -> master)
//   wr_ch    : channel 0-7
//   wr_mask  : operator mask, [0]=M1 [1]=C1 [2]=M2 [3]=C2
interface jt51_kon_seq_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_ch;
  logic [3:0] wr_mask;

  modport master (output wr_valid, output wr_ch, output wr_mask, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_mask, output wr_ready);
endinterface

// File: rtl/jt51_kon_seq.sv
// Key-on sequencer for the envelope generator's keyon_II input.
// The module holds the 32-slot key state. It serialises that state one slot
// per cen, in envelope slot order. Register writes and CSM bursts take
// effect only on a frame boundary, so each update is atomic per sample.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   cen       : clock enable for all slot-rate logic
//   zero      : frame marker; the cen cycle that loads slot 0
//   wr        : key-on write channel (slave side)
//   csm_en    : CSM mode enable
//   csm_ovf   : timer-A overflow pulse, sampled on cen
//   keyon_II  : key state of the slot currently at envelope stage II
//   frame_upd : one-cen pulse when a boundary applied any update
//   dbg_state : write-holding FSM state
module jt51_kon_seq
  import jt51_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 zero,
  jt51_kon_seq_if.slave        wr,
  input  logic                 csm_en,
  input  logic                 csm_ovf,
  output logic                 keyon_II,
  output logic                 frame_upd,
  output kon_state_t           dbg_state
);

  kon_state_t        state_q, state_d;
  logic [NSLOTS-1:0] kst, kst_next;
  logic [4:0]        cnt, slot;
  logic [2:0]        pend_ch;
  logic [3:0]        pend_mask;
  logic              csm_pend, csm_pend_next;
  logic              csm_act, csm_act_next;
  logic              boundary, accept, key_bit;

  assign wr.wr_ready = (state_q == ST_IDLE) && !rst;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign dbg_state   = state_q;

  // A boundary is the cen cycle that loads slot 0. That happens on the wrap
  // or whenever zero arrives, and zero also resynchronises the counter.
  assign boundary = cen && (zero || (cnt == 5'd0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_PEND;
      ST_PEND: if (boundary) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    kst_next      = kst;
    csm_act_next  = csm_act;
    csm_pend_next = csm_pend;
    slot          = cnt;
    if (boundary) begin
      slot = 5'd0;
      if (state_q == ST_PEND)
        kst_next = (kst & ~chan_slots(pend_ch)) | mask_to_slots(pend_ch, pend_mask);
      // The burst lasts one frame. A request that arrives during the burst
      // extends it by exactly one more frame.
      csm_act_next  = csm_pend;
      csm_pend_next = 1'b0;
    end
    // An overflow on the boundary cycle itself is held for the next boundary.
    if (cen && csm_ovf && csm_en) csm_pend_next = 1'b1;
    // On a boundary, slot 0 is loaded from the updated state, so the whole
    // frame sees the new keys.
    key_bit = kst_next[slot] | csm_act_next;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kst       <= '0;
      cnt       <= 5'd0;
      pend_ch   <= 3'd0;
      pend_mask <= 4'd0;
      csm_pend  <= 1'b0;
      csm_act   <= 1'b0;
      keyon_II  <= 1'b0;
      frame_upd <= 1'b0;
    end else begin
      if (accept) begin
        pend_ch   <= wr.wr_ch;
        pend_mask <= wr.wr_mask;
      end
      kst      <= kst_next;
      csm_pend <= csm_pend_next;
      csm_act  <= csm_act_next;
      if (cen) begin
        keyon_II  <= key_bit;
        cnt       <= slot + 5'd1;
        frame_upd <= boundary && ((state_q == ST_PEND) || (csm_act_next != csm_act));
      end
    end
  end

endmodule

// File: tb/tb_jt51_kon_seq.sv
// Bench for jt51_kon_seq.
// cen runs at half the clk rate. zero is driven every 32 cen.
// A slot-level model pushes the expected {frame_upd, keyon_II} value for
// every cen. The value is popped and compared after that edge.
// Whole frames are also captured and compared against literal patterns.
module tb_jt51_kon_seq;
  import jt51_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  logic zero = 1'b0;
  logic csm_en = 1'b0;
  logic csm_ovf = 1'b0;
  logic keyon_II, frame_upd;
  kon_state_t dbg_state;

  jt51_kon_seq_if wr_bus();

  jt51_kon_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .zero      (zero),
    .wr        (wr_bus),
    .csm_en    (csm_en),
    .csm_ovf   (csm_ovf),
    .keyon_II  (keyon_II),
    .frame_upd (frame_upd),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [1:0]  exp_q[$];
  logic [31:0] m_kst = '0;
  bit          m_pend = 0;
  logic [2:0]  m_ch = '0;
  logic [3:0]  m_mask = '0;
  bit          m_csm_pend = 0;
  bit          m_csm_act = 0;
  logic [4:0]  m_cnt = '0;
  int          ph = 0;
  logic [31:0] cap = '0;
  int          upd_cnt = 0;
  bit          last_acc = 0;

  // One clk cycle: update the model with the current inputs, take the edge,
  // then check the outputs.
  task automatic cycle();
    bit         cen_now, bnd, upd, rdy, kbit;
    logic [4:0] slot;
    logic [1:0] e;
    cen_now  = cen;
    zero     = cen && (ph == 0);
    last_acc = 0;
    slot     = '0;
    rdy      = !m_pend && !rst;
    if (rst) begin
      m_kst = '0; m_pend = 0; m_csm_pend = 0; m_csm_act = 0; m_cnt = '0; ph = 0;
      if (cen_now) exp_q.push_back(2'b00);
    end else begin
      if (cen_now) begin
        bnd = zero || (m_cnt == 5'd0);
        upd = 0;
        if (bnd) begin
          slot = 5'd0;
          if (m_pend) begin
            m_kst[{2'd0, m_ch}] = m_mask[0];
            m_kst[{2'd1, m_ch}] = m_mask[2];
            m_kst[{2'd2, m_ch}] = m_mask[1];
            m_kst[{2'd3, m_ch}] = m_mask[3];
            m_pend = 0;
            upd = 1;
          end
          if (m_csm_act != m_csm_pend) upd = 1;
          m_csm_act  = m_csm_pend;
          m_csm_pend = 0;
        end else begin
          slot = m_cnt;
        end
        if (csm_ovf && csm_en) m_csm_pend = 1;
        kbit  = m_kst[slot] | m_csm_act;
        m_cnt = slot + 5'd1;
        exp_q.push_back({upd, kbit});
        ph = (ph + 1) % 32;
      end
      if (wr_bus.wr_valid && rdy) begin
        last_acc = 1;
        m_pend   = 1;
        m_ch     = wr_bus.wr_ch;
        m_mask   = wr_bus.wr_mask;
      end
    end
    @(posedge clk);
    #1;
    check("wr_ready", wr_bus.wr_ready, !m_pend && !rst);
    if (rst) check("rst_keyon", keyon_II, 0);
    if (cen_now) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("keyon_II", keyon_II, e[0]);
        check("frame_upd", frame_upd, e[1]);
        if (!rst) begin
          cap[slot] = keyon_II;
          if (frame_upd) upd_cnt++;
        end
      end
    end
    cen = ~cen;
  endtask

  // ---------------- driver tasks ----------------
  task automatic sync_frame();
    int guard = 0;
    while (!(cen && ph == 0) && guard < 200) begin
      cycle();
      guard++;
    end
    if (guard >= 200) check("sync_timeout", 1, 0);
  endtask

  // Captures one frame of 32 cen, starting at a boundary.
  task automatic run_frame(input bit wr_start, output logic [31:0] f, output int u);
    int n = 0;
    bit was;
    cap = '0;
    upd_cnt = 0;
    if (wr_start) wr_bus.wr_valid = 1'b1;
    while (n < 32) begin
      was = cen;
      cycle();
      wr_bus.wr_valid = 1'b0;
      if (was) n++;
    end
    f = cap;
    u = upd_cnt;
  endtask

  task automatic write(input logic [2:0] ch, input logic [3:0] mask, output int waited);
    waited = 0;
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_ch    = ch;
    wr_bus.wr_mask  = mask;
    do begin
      cycle();
      waited++;
    end while (!last_acc && waited < 200);
    wr_bus.wr_valid = 1'b0;
    if (!last_acc) check("wr_timeout", 0, 1);
  endtask

  task automatic csm_pulse();
    bit was;
    int guard = 0;
    csm_ovf = 1'b1;
    do begin
      was = cen;
      cycle();
      guard++;
    end while (!was && guard < 4);
    csm_ovf = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] f;
    int u, w;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_ch    = 3'd0;
    wr_bus.wr_mask  = 4'd0;

    repeat (4) cycle();
    rst = 1'b0;

    sync_frame();
    run_frame(0, f, u); check("idle_frame0", f, 32'h0); check("idle_upd0", u, 0);
    run_frame(0, f, u); check("idle_frame1", f, 32'h0);

    repeat (9) cycle();
    write(3'd3, 4'b1111, w);
    sync_frame();
    run_frame(0, f, u); check("ch3_all", f, 32'h08080808); check("ch3_upd", u, 1);

    repeat (7) cycle();
    write(3'd5, 4'b0010, w);
    write(3'd0, 4'b0001, w);
    check("second_wr_stalled", (w > 10), 1);
    sync_frame();
    run_frame(0, f, u); check("ch5_c1_ch0_m1", f, 32'h08280809); check("ch0_upd", u, 1);

    write(3'd0, 4'b0000, w);
    write(3'd5, 4'b0000, w);
    sync_frame();
    run_frame(0, f, u); check("clear_ch0_ch5", f, 32'h08080808);

    csm_en = 1'b1;
    repeat (5) cycle();
    csm_pulse();
    sync_frame();
    run_frame(0, f, u); check("csm_burst", f, 32'hffffffff); check("csm_on_upd", u, 1);
    run_frame(0, f, u); check("csm_after", f, 32'h08080808); check("csm_off_upd", u, 1);
    run_frame(0, f, u); check("csm_quiet", f, 32'h08080808); check("csm_quiet_upd", u, 0);

    csm_en = 1'b0;
    repeat (5) cycle();
    csm_pulse();
    sync_frame();
    run_frame(0, f, u); check("csm_disabled", f, 32'h08080808); check("csm_dis_upd", u, 0);

    sync_frame();
    wr_bus.wr_ch   = 3'd7;
    wr_bus.wr_mask = 4'b1000;
    run_frame(1, f, u); check("bnd_wr_held", f, 32'h08080808); check("bnd_wr_upd0", u, 0);
    run_frame(0, f, u); check("bnd_wr_applied", f, 32'h88080808); check("bnd_wr_upd1", u, 1);

    csm_en = 1'b1;
    repeat (3) cycle();
    csm_pulse();
    write(3'd1, 4'b1111, w);
    sync_frame();
    run_frame(0, f, u); check("wr_csm_burst", f, 32'hffffffff); check("wr_csm_upd", u, 1);
    run_frame(0, f, u); check("wr_csm_after", f, 32'h8a0a0a0a);

    repeat (3) cycle();
    csm_pulse();
    sync_frame();
    csm_en = 1'b0;
    run_frame(0, f, u); check("csm_en_drop_burst", f, 32'hffffffff);
    run_frame(0, f, u); check("csm_en_drop_after", f, 32'h8a0a0a0a);

    repeat (11) cycle();
    ph = 0;
    sync_frame();
    run_frame(0, f, u); check("resync_frame", f, 32'h8a0a0a0a); check("resync_upd", u, 0);

    csm_en = 1'b1;
    csm_pulse();
    sync_frame();
    repeat (10) cycle();
    write(3'd4, 4'b1111, w);
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_keyon_direct", keyon_II, 0);
    rst = 1'b0;
    sync_frame();
    run_frame(0, f, u); check("post_rst_frame0", f, 32'h0); check("post_rst_upd", u, 0);
    run_frame(0, f, u); check("post_rst_frame1", f, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
